// File: rtl/sysarray_mm_stream_if.sv
// Host-side bundle for the systolic matrix multiplier: job control, operand
// beat stream and result row stream.
interface sysarray_mm_stream_if #(
   parameter int DW   = 16,
   parameter int N    = 4,
   parameter int KMAX = 64,
   parameter int ACCW = 2*DW + $clog2(KMAX)
) ();
   logic                      start;
   logic [$clog2(KMAX):0]     k_len;
   logic                      signed_mode;
   logic                      in_valid;
   logic                      in_ready;
   logic [N*DW-1:0]           a_vec;
   logic [N*DW-1:0]           b_vec;
   logic                      out_valid;
   logic                      out_ready;
   logic [$clog2(N)-1:0]      out_row_idx;
   logic [N*ACCW-1:0]         out_row;
   logic                      busy;
   logic                      done;

   modport master (
      output start, k_len, signed_mode, in_valid, a_vec, b_vec, out_ready,
      input  in_ready, out_valid, out_row_idx, out_row, busy, done
   );

   modport slave (
      input  start, k_len, signed_mode, in_valid, a_vec, b_vec, out_ready,
      output in_ready, out_valid, out_row_idx, out_row, busy, done
   );
endinterface

// File: rtl/sysarray_mm_stream.sv
// Output-stationary NxN systolic multiplier C = A x B with runtime K and sign
// mode; operands are skewed internally and results drain one row per handshake.
module sysarray_mm_stream #(
   parameter int DW   = 16,
   parameter int N    = 4,
   parameter int KMAX = 64,
   parameter int ACCW = 2*DW + $clog2(KMAX)
) (
   input  logic                clk,
   input  logic                rst_n,
   sysarray_mm_stream_if.slave bus
);

   localparam int KW  = $clog2(KMAX) + 1;
   localparam int RW  = $clog2(N);
   localparam int DCW = $clog2(2*N);
   // Extended signed product width; ACCW must exceed it (holds for KMAX >= 8).
   localparam int PW  = 2*DW + 2;
   localparam logic [KW-1:0]  KMAX_K     = KW'(KMAX);
   localparam logic [KW-1:0]  K_ONE      = KW'(1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2*N - 2);
   localparam logic [DCW-1:0] DCW_ONE    = DCW'(1);
   localparam logic [RW-1:0]  ROW_LAST   = RW'(N - 1);
   localparam logic [RW-1:0]  RW_ONE     = RW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [KW-1:0]  k_q, k_d;
   logic [KW-1:0]  beat_q, beat_d;
   logic           sign_q, sign_d;
   logic [DCW-1:0] drain_q, drain_d;
   logic [RW-1:0]  row_q, row_d;
   logic           done_q, done_d;
   logic           clear;
   logic           beat_tag;

   // Operand/tag wavefronts: a_h[i][j] and b_v[i][j] are the inputs of PE(i,j).
   logic [N-1:0][N-1:0][DW-1:0] a_h;
   logic [N-1:0][N-1:0]         av_h;
   logic [N-1:0][N-1:0][DW-1:0] b_v;
   logic [N-1:0][N-1:0]         bv_v;
   logic [N-1:0][N*ACCW-1:0]    acc_rows;

   assign beat_tag = (state_q == S_FEED) & bus.in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         beat_q  <= '0;
         sign_q  <= 1'b0;
         drain_q <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         beat_q  <= beat_d;
         sign_q  <= sign_d;
         drain_q <= drain_d;
         row_q   <= row_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      sign_d  = sign_q;
      beat_d  = beat_q;
      drain_d = drain_q;
      row_d   = row_q;
      done_d  = 1'b0;
      clear   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               clear   = 1'b1;
               k_d     = (bus.k_len > KMAX_K) ? KMAX_K : bus.k_len;
               sign_d  = bus.signed_mode;
               beat_d  = '0;
               drain_d = '0;
               row_d   = '0;
               state_d = (k_d == '0) ? S_OUT : S_FEED;
            end
         end
         S_FEED: begin
            if (beat_tag) begin
               beat_d = beat_q + K_ONE;
               if (beat_d == k_q) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) state_d = S_OUT;
            else                       drain_d = drain_q + DCW_ONE;
         end
         S_OUT: begin
            if (bus.out_ready) begin
               if (row_q == ROW_LAST) begin
                  row_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  row_d = row_q + RW_ONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Row i of A and column i of B each see i+1 register stages before the array.
   genvar gi, gj;
   for (gi = 0; gi < N; gi++) begin : g_skew
      logic [DW-1:0] ad_q [gi+1];
      logic          av_q [gi+1];
      logic [DW-1:0] bd_q [gi+1];
      logic          bv_q [gi+1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s <= gi; s++) begin
               ad_q[s] <= '0;
               av_q[s] <= 1'b0;
               bd_q[s] <= '0;
               bv_q[s] <= 1'b0;
            end
         end else begin
            ad_q[0] <= bus.a_vec[gi*DW +: DW];
            bd_q[0] <= bus.b_vec[gi*DW +: DW];
            av_q[0] <= beat_tag & ~clear;
            bv_q[0] <= beat_tag & ~clear;
            for (int s = 1; s <= gi; s++) begin
               ad_q[s] <= ad_q[s-1];
               bd_q[s] <= bd_q[s-1];
               av_q[s] <= av_q[s-1] & ~clear;
               bv_q[s] <= bv_q[s-1] & ~clear;
            end
         end
      end

      assign a_h[gi][0]  = ad_q[gi];
      assign av_h[gi][0] = av_q[gi];
      assign b_v[0][gi]  = bd_q[gi];
      assign bv_v[0][gi] = bv_q[gi];
   end

   for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
         logic [DW-1:0]        a_in, b_in;
         logic                 av_in, bv_in;
         logic signed [DW:0]   a_ext, b_ext;
         logic signed [PW-1:0] prod;
         logic [ACCW-1:0]      acc_q;

         assign a_in  = a_h[gi][gj];
         assign av_in = av_h[gi][gj];
         assign b_in  = b_v[gi][gj];
         assign bv_in = bv_v[gi][gj];
         assign a_ext = {sign_q & a_in[DW-1], a_in};
         assign b_ext = {sign_q & b_in[DW-1], b_in};
         assign prod  = a_ext * b_ext;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)              acc_q <= '0;
            else if (clear)          acc_q <= '0;
            else if (av_in && bv_in) acc_q <= acc_q + {{(ACCW-PW){prod[PW-1]}}, prod};
         end

         assign acc_rows[gi][gj*ACCW +: ACCW] = acc_q;

         if (gj < N-1) begin : g_pass_a
            logic [DW-1:0] a_q;
            logic          av_q;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  a_q  <= '0;
                  av_q <= 1'b0;
               end else begin
                  a_q  <= a_in;
                  av_q <= av_in & ~clear;
               end
            end
            assign a_h[gi][gj+1]  = a_q;
            assign av_h[gi][gj+1] = av_q;
         end

         if (gi < N-1) begin : g_pass_b
            logic [DW-1:0] b_q;
            logic          bv_q;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  b_q  <= '0;
                  bv_q <= 1'b0;
               end else begin
                  b_q  <= b_in;
                  bv_q <= bv_in & ~clear;
               end
            end
            assign b_v[gi+1][gj]  = b_q;
            assign bv_v[gi+1][gj] = bv_q;
         end
      end
   end

   assign bus.in_ready    = (state_q == S_FEED);
   assign bus.out_valid   = (state_q == S_OUT);
   assign bus.out_row_idx = row_q;
   assign bus.out_row     = acc_rows[row_q];
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;

endmodule

// File: tb/tb_sysarray_mm_stream.sv
// Directed bench for sysarray_mm_stream: a driver pushes expected rows into a
// scoreboard queue, a negedge monitor pops and compares on each row handshake.
module tb_sysarray_mm_stream;
   localparam int DW   = 16;
   localparam int N    = 4;
   localparam int KMAX = 64;
   localparam int ACCW = 2*DW + $clog2(KMAX);
   localparam int KW   = $clog2(KMAX) + 1;

   typedef struct {
      int                idx;
      logic [N*ACCW-1:0] row;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   int   cyc = 0;
   bit   prev_done = 1'b0;
   exp_t exp_q[$];

   logic [DW-1:0] am [N][KMAX];
   logic [DW-1:0] bm [KMAX][N];
   longint        ec [N][N];

   sysarray_mm_stream_if #(.DW(DW), .N(N), .KMAX(KMAX)) bus ();

   sysarray_mm_stream #(.DW(DW), .N(N), .KMAX(KMAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [N*ACCW-1:0] act, input logic [N*ACCW-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Each PE must only ever see both operands tagged valid or neither.
   for (genvar gi = 0; gi < N; gi++) begin : g_tag_chk
      for (genvar gj = 0; gj < N; gj++) begin : g_tag_col
         always @(negedge clk)
            if (rst_n)
               chk("tag_match", dut.g_row[gi].g_col[gj].av_in, dut.g_row[gi].g_col[gj].bv_in);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_row: got row %0d, required none", bus.out_row_idx);
         end else begin
            e = exp_q.pop_front();
            chk("row_idx", bus.out_row_idx, e.idx);
            chk("row_data", bus.out_row, e.row);
            $display("row %0d: %0h", bus.out_row_idx, bus.out_row);
         end
      end
      if (rst_n && bus.done) begin
         done_cnt++;
         chk("done_after_rows", exp_q.size(), 0);
         chk("done_single", prev_done, 1'b0);
      end
      prev_done = rst_n && bus.done;
   end

   task automatic clear_mats();
      for (int i = 0; i < N; i++)
         for (int t = 0; t < KMAX; t++) begin
            am[i][t] = '0;
            bm[t][i] = '0;
         end
   endtask

   task automatic load_ident();
      clear_mats();
      for (int i = 0; i < N; i++) begin
         am[i][i] = 16'd1;
         for (int j = 0; j < N; j++) bm[i][j] = DW'(i*N + j + 1);
      end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) ec[r][c] = longint'(r*N + c + 1);
   endtask

   task automatic set_row(input int r, input longint c0, input longint c1, input longint c2, input longint c3);
      ec[r][0] = c0; ec[r][1] = c1; ec[r][2] = c2; ec[r][3] = c3;
   endtask

   task automatic model(input int k, input bit sgn);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            longint s = 0;
            for (int t = 0; t < k; t++) begin
               longint x, y;
               if (sgn) begin
                  x = longint'($signed(am[r][t]));
                  y = longint'($signed(bm[t][c]));
               end else begin
                  x = longint'(am[r][t]);
                  y = longint'(bm[t][c]);
               end
               s += x * y;
            end
            ec[r][c] = s;
         end
   endtask

   task automatic push_exp();
      for (int r = 0; r < N; r++) begin
         exp_t e;
         e.idx = r;
         for (int c = 0; c < N; c++) begin
            longint v = ec[r][c];
            e.row[c*ACCW +: ACCW] = v[ACCW-1:0];
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic run_job(input int klen, input int kfeed, input bit sgn, input bit toggle,
                          input bit bp, input int exp_lat);
      int start_cyc, acc, budget, d0;
      bit ph, vld, took;
      d0 = done_cnt;
      push_exp();
      bus.k_len       = KW'(klen);
      bus.signed_mode = sgn;
      bus.start       = 1'b1;
      start_cyc       = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
      acc = 0; budget = 0; ph = 1'b1;
      while (acc < kfeed && budget < 4*KMAX) begin
         vld = toggle ? ph : 1'b1;
         ph  = ~ph;
         for (int i = 0; i < N; i++) begin
            bus.a_vec[i*DW +: DW] = vld ? am[i][acc] : '1;
            bus.b_vec[i*DW +: DW] = vld ? bm[acc][i] : '1;
         end
         bus.in_valid = vld;
         took = vld && bus.in_ready;
         @(posedge clk); #1;
         if (took) acc++;
         budget++;
      end
      chk("beats_accepted", acc, kfeed);
      if (kfeed > 0) chk("in_ready_drop", bus.in_ready, 1'b0);
      // Junk beats offered after the feed phase must be ignored.
      bus.in_valid = toggle;
      bus.a_vec    = '1;
      bus.b_vec    = '1;
      budget = 0;
      while (!bus.out_valid && budget < 300) begin
         @(posedge clk); #1;
         budget++;
      end
      chk("out_valid_seen", bus.out_valid, 1'b1);
      if (exp_lat > 0) chk("latency", cyc - start_cyc, exp_lat);
      if (bp) begin
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
         for (int s = 0; s < 3; s++) begin
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_idx", bus.out_row_idx, 1);
            if (exp_q.size() > 0) chk("stall_row", bus.out_row, exp_q[0].row);
            @(posedge clk); #1;
         end
         bus.out_ready = 1'b1;
      end
      budget = 0;
      while (done_cnt == d0 && budget < 300) begin
         @(posedge clk); #1;
         budget++;
      end
      chk("done_count", done_cnt, d0 + 1);
      @(posedge clk); #1;
      chk("done_low", bus.done, 1'b0);
      chk("idle_busy", bus.busy, 1'b0);
      chk("rows_left", exp_q.size(), 0);
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no end, required $finish");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.k_len = '0; bus.signed_mode = 1'b0;
      bus.in_valid = 1'b0; bus.a_vec = '0; bus.b_vec = '0; bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.k_len = KW'(2);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_row_idx", bus.out_row_idx, 0);
      chk("rst_row", bus.out_row, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy", bus.busy, 1'b0);

      clear_mats();
      am[0][0] = 16'd1; am[0][1] = 16'd2; am[1][0] = 16'd3; am[1][1] = 16'd4;
      bm[0][0] = 16'd5; bm[0][1] = 16'd6; bm[1][0] = 16'd7; bm[1][1] = 16'd8;
      set_row(0, 19, 22, 0, 0); set_row(1, 43, 50, 0, 0);
      set_row(2, 0, 0, 0, 0);   set_row(3, 0, 0, 0, 0);
      run_job(2, 2, 1'b0, 1'b0, 1'b0, 1 + 2 + 2*N - 1);

      clear_mats();
      am[0][0] = 16'hFFFF; am[0][1] = 16'd2; am[1][0] = 16'd3; am[1][1] = 16'hFFFC;
      bm[0][0] = 16'd2;    bm[0][1] = 16'd0; bm[1][0] = 16'd0; bm[1][1] = 16'hFFFD;
      set_row(0, -2, -6, 0, 0); set_row(1, 6, 12, 0, 0);
      set_row(2, 0, 0, 0, 0);   set_row(3, 0, 0, 0, 0);
      run_job(2, 2, 1'b1, 1'b0, 1'b0, 1 + 2 + 2*N - 1);

      model(2, 1'b0);
      run_job(2, 2, 1'b0, 1'b0, 1'b0, 0);

      load_ident();
      run_job(4, 4, 1'b0, 1'b1, 1'b0, 0);

      load_ident();
      run_job(4, 4, 1'b0, 1'b0, 1'b1, 1 + 4 + 2*N - 1);

      for (int r = 0; r < N; r++) set_row(r, 0, 0, 0, 0);
      run_job(0, 0, 1'b1, 1'b0, 1'b0, 1);

      for (int i = 0; i < N; i++)
         for (int t = 0; t < KMAX; t++) begin
            am[i][t] = 16'h8000;
            bm[t][i] = 16'h8000;
         end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) ec[r][c] = longint'(1) << 36;
      run_job(KMAX, KMAX, 1'b1, 1'b0, 1'b0, 1 + KMAX + 2*N - 1);
      run_job(127, KMAX, 1'b1, 1'b0, 1'b0, 1 + KMAX + 2*N - 1);

      // Abort a job mid-feed with garbage operands, then rerun cleanly.
      for (int i = 0; i < N; i++)
         for (int t = 0; t < KMAX; t++) begin
            am[i][t] = 16'd9;
            bm[t][i] = 16'd9;
         end
      d0 = done_cnt;
      bus.k_len = KW'(4); bus.signed_mode = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a_vec = {N{16'd9}}; bus.b_vec = {N{16'd9}}; bus.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_in_ready", bus.in_ready, 1'b0);
      chk("abort_out_valid", bus.out_valid, 1'b0);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_no_done", done_cnt, d0);
      load_ident();
      run_job(4, 4, 1'b0, 1'b0, 1'b0, 1 + 4 + 2*N - 1);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
